uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between up to NREQ byte-stream requesters. It takes bytes over per-requester valid/ready handshakes and drives the UART register block's hardware-side data and one-cycle start inputs. It then waits for the transmitter's done indication before scheduling the next byte, and a watchdog recovers from a missing done. It sits between on-chip byte producers (CPU mailbox, debug/trace sources) and the UART TX datapath.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one UART transmitter
// between NREQ byte-stream requesters. A byte is accepted over a per-requester
// valid/ready handshake, handed to the transmitter with a one-cycle start
// pulse, and the next byte is only scheduled after the transmitter reports
// done. A watchdog returns the block to IDLE if done never arrives.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                uart_ready_in,
  input  logic                uart_tx_done_in,
  output logic [7:0]          uart_data_out,
  output logic                uart_start_out,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic                timeout_err,
  output logic [7:0]          err_cnt
);

  // Watchdog counter only has to reach TIMEOUT-1.
  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         data_q;
  logic               start_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_grant_q;
  logic               terr_q;
  logic [7:0]         err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               win_found_d;
  logic [ID_W-1:0]    win_idx_d;
  logic [ID_W-1:0]    cand_d;
  logic [7:0]         win_byte_d;
  logic               fire_d;

  // Error counter sticks at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Round-robin pick: first valid requester after the last grant, with wrap;
  // the handshake completes combinationally while idle and the UART is ready.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_d = ID_W'((int'(last_grant_q) + k) % NREQ);
      if (!win_found_d && req_valid[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
    win_byte_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_d == ID_W'(i)) win_byte_d = req_data[8*i +: 8];
    end
    fire_d    = (state_q == S_IDLE) && uart_ready_in && win_found_d;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = fire_d && (win_idx_d == ID_W'(i));
    end
  end

  // Scheduler FSM: accept byte, pulse start, wait for done or watchdog expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      data_q       <= 8'h00;
      start_q      <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= ID_LAST;
      terr_q       <= 1'b0;
      err_q        <= 8'h00;
      cnt_q        <= '0;
    end else begin
      start_q <= 1'b0;
      terr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fire_d) begin
            data_q       <= win_byte_d;
            grant_q      <= win_idx_d;
            last_grant_q <= win_idx_d;
            start_q      <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          // Done is ignored here so a stale pulse cannot end the next WAIT.
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (uart_tx_done_in) begin
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            terr_q  <= 1'b1;
            err_q   <= sat_inc(err_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_data_out  = data_q;
  assign uart_start_out = start_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != S_IDLE);
  assign timeout_err    = terr_q;
  assign err_cnt        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed stimulus, a cycle-level behavioural
// model checked every cycle, plus literal expectations for key scenarios.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              uart_ready_in;
  logic              uart_tx_done_in;
  logic [7:0]        uart_data_out;
  logic              uart_start_out;
  logic [ID_W-1:0]   grant_id;
  logic              busy;
  logic              timeout_err;
  logic [7:0]        err_cnt;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  uart_tx_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_ready_in(uart_ready_in),
    .uart_tx_done_in(uart_tx_done_in), .uart_data_out(uart_data_out),
    .uart_start_out(uart_start_out), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First valid requester after 'last', wrapping; -1 when none is valid.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural model: phase 0 idle, 1 start, 2 waiting for done.
  int         m_phase, m_waited, m_last;
  logic [7:0] m_data, m_err;
  logic [1:0] m_grant;
  logic       m_start, m_terr;

  always @(posedge clk) begin : model
    int w;
    if (!rst) begin
      m_phase <= 0; m_waited <= 0; m_last <= NREQ - 1; m_data <= 8'h00;
      m_grant <= 2'd0; m_start <= 1'b0; m_terr <= 1'b0; m_err <= 8'h00;
    end else begin
      m_start <= 1'b0;
      m_terr  <= 1'b0;
      if (m_phase == 0) begin
        w = pick(req_valid, m_last);
        if (uart_ready_in && w >= 0) begin
          m_phase <= 1;
          m_data  <= req_data[8*w +: 8];
          m_grant <= 2'(w);
          m_last  <= w;
          m_start <= 1'b1;
        end
      end else if (m_phase == 1) begin
        m_phase  <= 2;
        m_waited <= 0;
      end else begin
        if (uart_tx_done_in) m_phase <= 0;
        else if (m_waited + 1 == TIMEOUT) begin
          m_phase <= 0;
          m_terr  <= 1'b1;
          m_err   <= (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        end
        m_waited <= m_waited + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    int w;
    logic [NREQ-1:0] exp_rdy;
    if (armed) begin
      w = pick(req_valid, m_last);
      exp_rdy = (m_phase == 0 && uart_ready_in && w >= 0) ? NREQ'(1 << w) : '0;
      chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("m_data", 32'(uart_data_out), 32'(m_data));
      chk("m_start", 32'(uart_start_out), 32'(m_start));
      chk("m_grant", 32'(grant_id), 32'(m_grant));
      chk("m_busy", 32'(busy), 32'(m_phase != 0));
      chk("m_timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("m_err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 40; i++) begin
      if (uart_start_out) break;
      tick();
    end
    chk("start_seen", 32'(uart_start_out), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  int n;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0; req_valid = '0; req_data = '0;
    uart_ready_in = 1'b1; uart_tx_done_in = 1'b0;
    tick();
    armed = 1'b1;
    tick(); tick();
    rst = 1'b1;
    chk("rst_data", 32'(uart_data_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);

    // Single requester 2 with byte 0x5A.
    req_data[23:16] = 8'h5A; req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk("single_data", 32'(uart_data_out), 32'h5A);
    chk("single_start", 32'(uart_start_out), 32'd1);
    chk("single_grant", 32'(grant_id), 32'd2);
    tick();
    chk("single_start_gone", 32'(uart_start_out), 32'd0);
    tick(); tick();
    uart_tx_done_in = 1'b1; tick(); uart_tx_done_in = 1'b0;
    chk("single_idle_after_done", 32'(busy), 32'd0);

    // Transmitter not ready holds off the handshake.
    uart_ready_in = 1'b0; req_data[7:0] = 8'hC3; req_valid = 4'b0001;
    repeat (5) begin
      tick();
      chk("notready_no_ready", 32'(req_ready), 32'd0);
      chk("notready_no_start", 32'(uart_start_out), 32'd0);
    end
    uart_ready_in = 1'b1;
    @(negedge clk);
    chk("ready_rise_accept", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("ready_rise_data", 32'(uart_data_out), 32'hC3);
    tick(); tick();
    uart_tx_done_in = 1'b1; tick(); uart_tx_done_in = 1'b0;

    // Watchdog: no done at all.
    req_data[15:8] = 8'h77; req_valid = 4'b0010;
    wait_start();
    req_valid = '0;
    wait_idle(n);
    chk("timeout_len", 32'(n), 32'd17);
    chk("timeout_pulse", 32'(timeout_err), 32'd1);
    chk("timeout_cnt1", 32'(err_cnt), 32'd1);
    tick();
    chk("timeout_pulse_end", 32'(timeout_err), 32'd0);
    repeat (299) begin
      req_valid = 4'b0010;
      wait_start();
      req_valid = '0;
      wait_idle(n);
    end
    chk("err_saturated", 32'(err_cnt), 32'd255);

    // Reset during WAIT, then priority restarts at requester 0.
    req_valid = 4'b1000;
    wait_start();
    req_valid = '0;
    tick(); tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(uart_data_out), 32'h00);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_start", 32'(uart_start_out), 32'd0);
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    @(negedge clk);
    chk("prio_restart", 32'(req_ready), 32'b0001);

    // All four valid: round-robin order.
    for (int i = 0; i < 5; i++) begin
      wait_start();
      chk("rr_grant", 32'(grant_id), 32'(exp_order[i]));
      chk("rr_data", 32'(uart_data_out), 32'h10 + 32'(exp_order[i]));
      repeat (10) tick();
      if (i == 4) req_valid = '0;
      uart_tx_done_in = 1'b1; tick(); uart_tx_done_in = 1'b0;
    end

    // Done during START is ignored; done in WAIT cycle 5 ends it.
    req_valid = 4'b0100;
    wait_start();
    req_valid = '0;
    uart_tx_done_in = 1'b1; tick(); uart_tx_done_in = 1'b0;
    repeat (3) tick();
    chk("stale_done_ignored", 32'(busy), 32'd1);
    tick();
    uart_tx_done_in = 1'b1; tick(); uart_tx_done_in = 1'b0;
    chk("wait5_done_idle", 32'(busy), 32'd0);

    // Done coincident with the last watchdog cycle: no error.
    req_valid = 4'b0001;
    wait_start();
    req_valid = '0;
    tick();
    repeat (15) tick();
    uart_tx_done_in = 1'b1; tick(); uart_tx_done_in = 1'b0;
    chk("coinc_busy", 32'(busy), 32'd0);
    chk("coinc_no_terr", 32'(timeout_err), 32'd0);
    chk("coinc_err_cnt", 32'(err_cnt), 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
